uart_package_rx: RTL and testbench

//  Receive end of the two-byte UART package link: deserialises 8N1 frames from the serial line,

---
 rtl/uart_package_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_package_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_package_rx.sv
// Two-byte UART package receiver: 8N1 deserialiser that pairs bytes into a 16-bit package,
// with framing-error and inter-byte timeout reporting.
module uart_package_rx #(
    parameter int unsigned FREQUENCY    = 32'd50_000_000,
    parameter int unsigned SPEED        = 32'd9600,
    parameter int unsigned TIMEOUT_BITS = 32'd20
) (
    input  logic        CLK_i,
    input  logic        Reset_i,
    input  logic        Rx_i,
    output logic [15:0] package_o,
    output logic        package_valid_o,
    output logic        frame_error_o,
    output logic        timeout_o,
    output logic        busy_o
);

    localparam int unsigned DIVIDER = FREQUENCY / SPEED;
    localparam int unsigned CNT_W   = $clog2(DIVIDER);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVIDER / 2 - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q, rx_s_d;
    logic             rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte1_q, byte1_d;
    logic             byte_idx_q, byte_idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [15:0]      package_q, package_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             tout_q, tout_d;
    logic             busy_q, busy_d;
    logic             fall;

    always_comb begin
        state_d    = state_q;
        rx_meta_d  = Rx_i;
        rx_s_d     = rx_meta_q;
        rx_prev_d  = rx_s_q;
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte1_d    = byte1_q;
        byte_idx_d = byte_idx_q;
        tmo_d      = tmo_q;
        package_d  = package_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        tout_d     = 1'b0;
        fall       = rx_prev_q & ~rx_s_q;

        case (state_q)
            ST_IDLE: begin
                // A start edge coinciding with timeout expiry takes priority
                if (fall) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else if (byte_idx_q && cnt_q == CNT_LAST) begin
                    if (tmo_q == TMO_LAST) begin
                        tout_d     = 1'b1;
                        byte_idx_d = 1'b0;
                        tmo_d      = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                        if (byte_idx_q) begin
                            package_d  = {byte1_q, shift_q};
                            valid_d    = 1'b1;
                            byte_idx_d = 1'b0;
                        end else begin
                            byte1_d    = shift_q;
                            byte_idx_d = 1'b1;
                            tmo_d      = '0;
                        end
                    end else begin
                        ferr_d     = 1'b1;
                        byte_idx_d = 1'b0;
                        state_d    = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE) | byte_idx_d;
    end

    always_ff @(posedge CLK_i or negedge Reset_i) begin
        if (!Reset_i) begin
            state_q    <= ST_IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte1_q    <= '0;
            byte_idx_q <= 1'b0;
            tmo_q      <= '0;
            package_q  <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            tout_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            rx_prev_q  <= rx_prev_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte1_q    <= byte1_d;
            byte_idx_q <= byte_idx_d;
            tmo_q      <= tmo_d;
            package_q  <= package_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            tout_q     <= tout_d;
            busy_q     <= busy_d;
        end
    end

    assign package_o       = package_q;
    assign package_valid_o = valid_q;
    assign frame_error_o   = ferr_q;
    assign timeout_o       = tout_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_uart_package_rx.sv
// Scoreboard bench for uart_package_rx: stimulus pushes expected events (package, frame error,
// timeout) with their arrival cycle; a monitor pops and compares on every output pulse.
module tb_uart_package_rx;

    localparam int DIV = 10;
    localparam int TMO = 20;
    // start edge -> mid-stop sample: 2 sync flops, 1 edge-detect cycle, half start bit, 9 bits
    localparam int LAT = 2 + 1 + DIV / 2 + 9 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] package_o;
    logic        package_valid_o, frame_error_o, timeout_o, busy_o;

    uart_package_rx #(
        .FREQUENCY   (32'd1_000_000),
        .SPEED       (32'd100_000),
        .TIMEOUT_BITS(32'd20)
    ) dut (
        .CLK_i          (clk),
        .Reset_i        (rst_n),
        .Rx_i           (rx),
        .package_o      (package_o),
        .package_valid_o(package_valid_o),
        .frame_error_o  (frame_error_o),
        .timeout_o      (timeout_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int          kind;   // 0 package, 1 frame error, 2 timeout
        logic [15:0] data;
        int          at;
    } ev_t;

    ev_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    bit          have_b1 = 0;
    logic [7:0]  b1 = '0;
    int          last_stop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor
    logic [15:0] mon_pkg = '0;
    int          mon_n;
    int          mon_kind;
    ev_t         mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_pkg = '0;
        end else begin
            mon_n = int'(package_valid_o) + int'(frame_error_o) + int'(timeout_o);
            if (mon_n > 1) check("pulse_exclusive", mon_n, 1);
            if (mon_n >= 1) begin
                mon_kind = package_valid_o ? 0 : (frame_error_o ? 1 : 2);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", mon_kind + 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_kind", mon_kind, mon_e.kind);
                    check("event_cycle", cycle, mon_e.at);
                    if (mon_e.kind == 0) begin
                        check("package", package_o, mon_e.data);
                        mon_pkg = mon_e.data;
                    end
                end
            end
            if (!package_valid_o) check("package_hold", package_o, mon_pkg);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input logic [15:0] data, input int at);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Full 8N1 frame; a low stop bit is followed by low_hold extra low clocks then one high bit
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int low_hold);
        int t0;
        t0 = cycle;
        last_stop = t0 + LAT;
        if (!stop_ok) begin
            push_ev(1, '0, t0 + LAT);
            have_b1 = 0;
        end else if (have_b1) begin
            push_ev(0, {b1, b}, t0 + LAT);
            have_b1 = 0;
        end else begin
            b1 = b;
            have_b1 = 1;
        end
        rx = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(DIV);
        end
        rx = stop_ok;
        wait_cycles(DIV);
        if (!stop_ok) begin
            wait_cycles(low_hold);
            rx = 1'b1;
            wait_cycles(DIV);
        end
    endtask

    task automatic idle_bits(input int g);
        if (have_b1 && g >= TMO) begin
            push_ev(2, '0, last_stop + TMO * DIV);
            have_b1 = 0;
        end
        rx = 1'b1;
        wait_cycles(g * DIV);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) wait_cycles(1);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    logic [7:0] rb;
    int         gap;

    initial begin
        // Reset state
        wait_cycles(5);
        check("reset_package", package_o, 16'h0000);
        check("reset_pulses", {package_valid_o, frame_error_o, timeout_o}, 0);
        check("reset_busy", busy_o, 0);
        rst_n = 1'b1;
        wait_cycles(3);

        // 1: basic package
        send_frame(8'hA5, 1, 0);
        idle_bits(1);
        send_frame(8'h3C, 1, 0);
        idle_bits(2);
        drain("t1_drain");
        check("t1_busy", busy_o, 0);

        // 2: start glitch
        rx = 1'b0;
        wait_cycles(3);
        rx = 1'b1;
        wait_cycles(20);
        check("t2_busy", busy_o, 0);

        // 3: framing error, line held low
        send_frame(8'h55, 0, 30);
        idle_bits(2);
        send_frame(8'h12, 1, 0);
        idle_bits(1);
        send_frame(8'h34, 1, 0);
        idle_bits(2);
        drain("t3_drain");

        // 4: inter-byte timeout
        send_frame(8'hFF, 1, 0);
        check("t4_busy_held", busy_o, 1);
        idle_bits(25);
        check("t4_busy_after", busy_o, 0);
        send_frame(8'h01, 1, 0);
        idle_bits(1);
        send_frame(8'h02, 1, 0);
        idle_bits(2);
        drain("t4_drain");

        // 5: reset mid-DATA of byte 2
        send_frame(8'hAA, 1, 0);
        idle_bits(1);
        rx = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'hBB >> i);
            wait_cycles(DIV);
        end
        rst_n = 1'b0;
        have_b1 = 0;
        #1;
        check("t5_reset_package", package_o, 16'h0000);
        check("t5_reset_pulses", {package_valid_o, frame_error_o, timeout_o}, 0);
        check("t5_reset_busy", busy_o, 0);
        rx = 1'b1;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(DIV);
        check("t5_package_after", package_o, 16'h0000);
        send_frame(8'hC3, 1, 0);
        idle_bits(1);
        send_frame(8'h5A, 1, 0);
        idle_bits(2);
        drain("t5_drain");

        // 6: back-to-back frames
        send_frame(8'h00, 1, 0);
        send_frame(8'hFF, 1, 0);
        send_frame(8'h80, 1, 0);
        send_frame(8'h01, 1, 0);
        idle_bits(2);
        drain("t6_drain");

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            rb = 8'($urandom);
            send_frame(rb, $urandom_range(0, 9) != 0, int'($urandom_range(0, 20)));
            gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(22, 26))
                                              : int'($urandom_range(0, 4));
            idle_bits(gap);
        end
        idle_bits(TMO + 2);
        drain("rand_drain");
        check("final_busy", busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
